// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs R/I/J-format instruction fields into 32-bit MIPS words and streams
//   them into instruction memory at consecutive addresses starting at
//   BASE_ADDR. It is used on the program-load path before the core runs.
//   The module accepts one word per valid/ready handshake. The memory write
//   follows one cycle after the accept.
//   Optional feature macro: PROG_CHECKSUM_EN adds a 32-bit XOR checksum output
//   covering every word written since start/reset.
module instr_encoder_loader #(
  parameter int unsigned   DEPTH     = 64,
  parameter int unsigned   AW        = 6,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    fmt,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic [25:0]   jaddr,
  input  logic          last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
`ifdef PROG_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmtT;

  // The count value just before the final memory slot is written.
  localparam logic [AW:0] LAST_SLOT_COUNT = (AW+1)'(DEPTH - 1);

  stateT         state;
  logic [AW-1:0] ptr;
  logic [31:0]   encWord;
  logic          isReserved;
  logic          accept;
  logic          fillsLastSlot;

  // in_ready is combinational so that start can block an accept in the same cycle.
  assign in_ready      = (state == LOAD) && !start;
  assign accept        = in_valid && in_ready;
  assign fillsLastSlot = (count == LAST_SLOT_COUNT);

  // Pack the field bundle according to its format; reserved formats produce no word.
  always_comb begin
    // NOTE: giving every output a default first means no path can leave a value unassigned, so no latch is inferred.
    encWord    = '0;
    isReserved = 1'b0;
    case (fmtT'(fmt))
      FMT_R:   encWord = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   encWord = {opcode, rs, rt, imm};
      FMT_J:   encWord = {opcode, jaddr};
      default: isReserved = 1'b1;
    endcase
  end

  // Load FSM: it registers the write strobe, address and data, and it tracks the pointer, count and sticky flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from the same pre-edge values, which matches the hardware.
    if (reset) begin
      state     <= IDLE;
      ptr       <= BASE_ADDR;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      // The strobe lasts one cycle. A write registered on the previous edge still completes if start arrives.
      mem_we <= 1'b0;
      if (start) begin
        state    <= LOAD;
        ptr      <= BASE_ADDR;
        count    <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
        checksum <= '0;
`endif
      end else if (accept) begin
        if (isReserved) begin
          // The handshake completes, but nothing is written. Only the error flag and a pending 'last' take effect.
          err <= 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= encWord;
          count     <= count + (AW+1)'(1);
`ifdef PROG_CHECKSUM_EN
          checksum  <= checksum ^ encWord;
`endif
          // The pointer saturates at the final slot, so it can never wrap back over loaded words.
          if (!fillsLastSlot) ptr <= ptr + AW'(1);
          if (last || fillsLastSlot) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
//   Directed-vector bench for instr_encoder_loader. The DUT is built with DEPTH=4
//   so that the memory-full case is reachable. Expected words are hand-computed.
//   If PROG_CHECKSUM_EN is defined, the bench also checks the checksum output.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, last;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic [25:0]   jaddr;
  logic          mem_we, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
`ifdef PROG_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checkCount = 0;
  int errorCount = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(2'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fmt      (fmt),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .jaddr    (jaddr),
    .last     (last),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .count    (count),
    .done     (done),
    .err      (err)
`ifdef PROG_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic setR(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [4:0] sh, input logic [5:0] fn);
    fmt = 2'b00; opcode = 6'd0; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
  endtask

  task automatic setI(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic [15:0] im);
    fmt = 2'b01; opcode = op; rs = s; rt = t; imm = im;
  endtask

  task automatic setJ(input logic [5:0] op, input logic [25:0] ja);
    fmt = 2'b10; opcode = op; jaddr = ja;
  endtask

  // Present the bundle that is already loaded for one accepting edge, then drop valid.
  task automatic send(input logic isLast);
    in_valid = 1'b1;
    last     = isLast;
    tick();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm = '0; jaddr = '0;

    // 1. Reset values.
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_addr",     32'(mem_addr), 32'd0);
    check("rst_wdata",    mem_wdata,     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
`ifdef PROG_CHECKSUM_EN
    check("rst_csum",     checksum,      32'd0);
`endif
    reset = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // 2. Start, then one R word. While start is high, in_ready stays low.
    start = 1'b1;
    #1;
    check("start_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    #1;
    check("load_in_ready", 32'(in_ready), 32'd1);
    setR(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    send(1'b0);
    check("r_we",    32'(mem_we),   32'd1);
    check("r_addr",  32'(mem_addr), 32'd0);
    check("r_wdata", mem_wdata,     32'h0022_1820);
    check("r_count", 32'(count),    32'd1);
    tick();
    check("r_we_1cyc",   32'(mem_we), 32'd0);
    check("r_wdata_hold", mem_wdata,  32'h0022_1820);

    // 3. I word, then J word with last.
    setI(6'h23, 5'd1, 5'd2, 16'd4);
    send(1'b0);
    check("i_we",    32'(mem_we),   32'd1);
    check("i_addr",  32'(mem_addr), 32'd1);
    check("i_wdata", mem_wdata,     32'h8C22_0004);
    setJ(6'd2, 26'h10);
    send(1'b1);
    check("j_we",       32'(mem_we),   32'd1);
    check("j_addr",     32'(mem_addr), 32'd2);
    check("j_wdata",    mem_wdata,     32'h0800_0010);
    check("j_count",    32'(count),    32'd3);
    check("j_done",     32'(done),     32'd1);
    check("j_in_ready", 32'(in_ready), 32'd0);
`ifdef PROG_CHECKSUM_EN
    check("j_csum",     checksum,      32'h8400_1834);
`endif

    // 4. Reserved format mid-stream.
    pulseStart();
    check("restart_done",  32'(done),  32'd0);
    check("restart_count", 32'(count), 32'd0);
    setR(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    send(1'b0);
    fmt = 2'b11;
    send(1'b0);
    check("rsv_we",       32'(mem_we),   32'd0);
    check("rsv_err",      32'(err),      32'd1);
    check("rsv_count",    32'(count),    32'd1);
    check("rsv_in_ready", 32'(in_ready), 32'd1);
    setI(6'h23, 5'd1, 5'd2, 16'd4);
    send(1'b0);
    check("post_rsv_addr",  32'(mem_addr), 32'd1);
    check("post_rsv_wdata", mem_wdata,     32'h8C22_0004);
    check("post_rsv_err",   32'(err),      32'd1);
`ifdef PROG_CHECKSUM_EN
    check("post_rsv_csum",  checksum,      32'h8C00_1824);
`endif

    // 4b. A reserved word carrying last still completes the load.
    pulseStart();
    check("restart_err", 32'(err), 32'd0);
    fmt = 2'b11;
    send(1'b1);
    check("rsv_last_done",  32'(done),     32'd1);
    check("rsv_last_ready", 32'(in_ready), 32'd0);
    check("rsv_last_we",    32'(mem_we),   32'd0);
    check("rsv_last_count", 32'(count),    32'd0);

    // start together with in_valid: start wins, then the held word is accepted.
    setJ(6'd3, 26'h3FF_FFFF);
    in_valid = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("start_win_we",    32'(mem_we), 32'd0);
    check("start_win_count", 32'(count),  32'd0);
    tick();
    in_valid = 1'b0;
    check("held_we",    32'(mem_we), 32'd1);
    check("held_wdata", mem_wdata,   32'h0FFF_FFFF);

    // 5. Fill all DEPTH slots without last; the fifth word is never accepted.
    pulseStart();
    for (int k = 0; k < 4; k++) begin
      setJ(6'd2, 26'(k + 1));
      send(1'b0);
      check($sformatf("full_addr%0d", k),  32'(mem_addr), 32'(k));
      check($sformatf("full_wdata%0d", k), mem_wdata,     32'h0800_0000 | 32'(k + 1));
    end
    check("full_done",  32'(done),     32'd1);
    check("full_count", 32'(count),    32'd4);
    setJ(6'd2, 26'd5);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("full_no_we%0d", k), 32'(mem_we),   32'd0);
      check($sformatf("full_ready%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("full_count_hold", 32'(count), 32'd4);

    // 6. Reset on the accepting edge squashes the write that would follow it.
    pulseStart();
    setR(5'd7, 5'd8, 5'd9, 5'd1, 6'h2A);
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    check("sq_we",       32'(mem_we),   32'd0);
    check("sq_addr",     32'(mem_addr), 32'd0);
    check("sq_wdata",    mem_wdata,     32'd0);
    check("sq_count",    32'(count),    32'd0);
    check("sq_done",     32'(done),     32'd0);
    check("sq_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("sq_we_after", 32'(mem_we),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
